// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and stage control structs for the MIPS pipeline controller.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Full control word produced in Decode and held in E.
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       regdst;
    logic       alusrc;
    logic [2:0] alucontrol;
    logic       valid;
  } ctrl_t;

  // Only the bits still needed once the ALU stage is behind us.
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
    logic valid;
  } ctrlM_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic valid;
  } ctrlW_t;

endpackage

// File: rtl/pipe_controller_if.sv
// Decode inputs and per-stage control outputs of the pipeline controller.
interface pipe_controller_if #(parameter int RETW = 32);
  logic [5:0]      op;
  logic [5:0]      funct;
  logic            equalID;
  logic            flushE;
  logic            pcsrcD;
  logic            branchD;
  logic            illegalD;
  logic            regdstE;
  logic            alusrcE;
  logic [2:0]      alucontrolE;
  logic            regwriteE;
  logic            memtoregE;
  logic            regwriteM;
  logic            memtoregM;
  logic            memwriteM;
  logic            regwriteW;
  logic            memtoregW;
  logic [RETW-1:0] retired;

  modport master (
    output op, funct, equalID, flushE,
    input  pcsrcD, branchD, illegalD, regdstE, alusrcE, alucontrolE,
           regwriteE, memtoregE, regwriteM, memtoregM, memwriteM,
           regwriteW, memtoregW, retired
  );

  modport slave (
    input  op, funct, equalID, flushE,
    output pcsrcD, branchD, illegalD, regdstE, alusrcE, alucontrolE,
           regwriteE, memtoregE, regwriteM, memtoregM, memwriteM,
           regwriteW, memtoregW, retired
  );
endinterface

// File: rtl/pipe_controller_ctrl_decoder.sv
// Combinational op/funct decoder. PIPE_CTRL_BNE_EN adds bne; without it bne is illegal.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       equalID,
  output ctrl_t      ctrl,
  output logic       branch,
  output logic       pcsrc,
  output logic       illegal
);

  logic beq, bne;

  // Decode table; anything unrecognised becomes an all-zero bubble flagged illegal.
  always_comb begin
    ctrl    = '0;
    beq     = 1'b0;
    bne     = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct != FN_NOP) begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
          ctrl.valid    = 1'b1;
          case (funct)
            FN_ADD:  ctrl.alucontrol = ALU_ADD;
            FN_SUB:  ctrl.alucontrol = ALU_SUB;
            FN_AND:  ctrl.alucontrol = ALU_AND;
            FN_OR:   ctrl.alucontrol = ALU_OR;
            FN_SLT:  ctrl.alucontrol = ALU_SLT;
            default: begin
              ctrl    = '0;
              illegal = 1'b1;
            end
          endcase
        end
      end
      OP_LW: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.alucontrol = ALU_ADD;
        ctrl.valid      = 1'b1;
      end
      OP_SW: begin
        ctrl.memwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
        ctrl.valid      = 1'b1;
      end
      OP_BEQ: begin
        beq             = 1'b1;
        ctrl.alucontrol = ALU_SUB;
        ctrl.valid      = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
        ctrl.valid      = 1'b1;
      end
`ifdef PIPE_CTRL_BNE_EN
      OP_BNE: begin
        bne             = 1'b1;
        ctrl.alucontrol = ALU_SUB;
        ctrl.valid      = 1'b1;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign branch = beq | bne;
  assign pcsrc  = (beq & equalID) | (bne & ~equalID);

endmodule

// File: rtl/pipe_controller.sv
// Pipelined MIPS control unit: Decode logic plus E/M/W control registers and a
// retired-instruction counter. Optional bne support via PIPE_CTRL_BNE_EN.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int RETW = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipe_controller_if.slave bus
);

  ctrl_t           ctrlD, ctrlE;
  ctrlM_t          ctrlM;
  ctrlW_t          ctrlW;
  logic [RETW-1:0] retired;

  ctrl_decoder uDec (
    .op      (bus.op),
    .funct   (bus.funct),
    .equalID (bus.equalID),
    .ctrl    (ctrlD),
    .branch  (bus.branchD),
    .pcsrc   (bus.pcsrcD),
    .illegal (bus.illegalD)
  );

  // Stage registers; a flush loads a bubble into E regardless of what Decode holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlE <= '0;
      ctrlM <= '0;
      ctrlW <= '0;
    end else begin
      ctrlE <= bus.flushE ? '0 : ctrlD;
      ctrlM <= '{regwrite: ctrlE.regwrite, memtoreg: ctrlE.memtoreg,
                 memwrite: ctrlE.memwrite, valid: ctrlE.valid};
      ctrlW <= '{regwrite: ctrlM.regwrite, memtoreg: ctrlM.memtoreg,
                 valid: ctrlM.valid};
    end
  end

  // Count valid instructions leaving W; wraps naturally at 2^RETW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           retired <= '0;
    else if (ctrlW.valid) retired <= retired + 1'b1;
  end

  assign bus.regdstE     = ctrlE.regdst;
  assign bus.alusrcE     = ctrlE.alusrc;
  assign bus.alucontrolE = ctrlE.alucontrol;
  assign bus.regwriteE   = ctrlE.regwrite;
  assign bus.memtoregE   = ctrlE.memtoreg;
  assign bus.regwriteM   = ctrlM.regwrite;
  assign bus.memtoregM   = ctrlM.memtoreg;
  assign bus.memwriteM   = ctrlM.memwrite;
  assign bus.regwriteW   = ctrlW.regwrite;
  assign bus.memtoregW   = ctrlW.memtoreg;
  assign bus.retired     = retired;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: directed vectors with hand-computed
// decode results; per-stage expectation queues checked by a separate monitor.
module tb_pipe_controller;
  import pipe_ctrl_pkg::*;

  localparam int RETW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_controller_if #(.RETW(RETW)) bus ();

  pipe_controller #(.RETW(RETW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         due;
    logic [5:0] op, funct;
    logic       eq, flush;
    logic       pc, br, il;
    logic       rw, mtr, mw, rd, as;
    logic [2:0] alu;
    logic       vld;
  } vec_t;

  typedef struct {
    int              due;
    logic [RETW-1:0] val;
  } ret_t;

  vec_t tbl[$];
  vec_t qD[$], qE[$], qM[$], qW[$];
  ret_t qR[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit finishReq = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic addV(input logic [5:0] op, input logic [5:0] funct, input logic eq,
                      input logic flush, input logic pc, input logic br, input logic il,
                      input logic rw, input logic mtr, input logic mw, input logic rd,
                      input logic as, input logic [2:0] alu, input logic vld);
    vec_t v;
    v.due = 0; v.op = op; v.funct = funct; v.eq = eq; v.flush = flush;
    v.pc = pc; v.br = br; v.il = il; v.rw = rw; v.mtr = mtr; v.mw = mw;
    v.rd = rd; v.as = as; v.alu = alu; v.vld = vld;
    tbl.push_back(v);
  endtask

  task automatic addNop(input int n);
    for (int i = 0; i < n; i++)
      addV(6'h00, 6'h00, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
  endtask

  // Monitor: reset-state checks while reset is low, otherwise pop due expectations.
  initial begin
    vec_t v;
    ret_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rstRegs", 32'({bus.regdstE, bus.alusrcE, bus.alucontrolE, bus.regwriteE,
                            bus.memtoregE, bus.regwriteM, bus.memtoregM, bus.memwriteM,
                            bus.regwriteW, bus.memtoregW}), 32'd0);
        chk("rstRetired", 32'(bus.retired), 32'd0);
        chk("rstIllegalD", 32'(bus.illegalD), 32'd0);
      end else begin
        while (qD.size() > 0 && qD[0].due == cyc) begin
          v = qD.pop_front();
          chk("D pc/br/il", 32'({bus.pcsrcD, bus.branchD, bus.illegalD}),
              32'({v.pc, v.br, v.il}));
        end
        while (qE.size() > 0 && qE[0].due == cyc) begin
          v = qE.pop_front();
          chk("E rw/mtr/rd/as/alu",
              32'({bus.regwriteE, bus.memtoregE, bus.regdstE, bus.alusrcE, bus.alucontrolE}),
              32'({v.rw, v.mtr, v.rd, v.as, v.alu}));
        end
        while (qM.size() > 0 && qM[0].due == cyc) begin
          v = qM.pop_front();
          chk("M rw/mtr/mw", 32'({bus.regwriteM, bus.memtoregM, bus.memwriteM}),
              32'({v.rw, v.mtr, v.mw}));
        end
        while (qW.size() > 0 && qW[0].due == cyc) begin
          v = qW.pop_front();
          chk("W rw/mtr", 32'({bus.regwriteW, bus.memtoregW}), 32'({v.rw, v.mtr}));
        end
        while (qR.size() > 0 && qR[0].due == cyc) begin
          r = qR.pop_front();
          chk("retired", 32'(bus.retired), 32'(r.val));
        end
      end
      if (finishReq) begin
        chk("undrained", 32'(qD.size() + qE.size() + qM.size() + qW.size() + qR.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  // Stimulus: one table vector per cycle; expectations pushed with their due cycle.
  initial begin
    vec_t v, e;
    ret_t r;
    logic [RETW-1:0] retModel;
    reset = 1'b0;
    bus.op = '0; bus.funct = '0; bus.equalID = 1'b0; bus.flushE = 1'b0;
    retModel = '0;

    addNop(5);
    //   op         funct      eq flush pc br il rw mtr mw rd as alu     vld
    addV(OP_LW,    6'h00,     0, 0,    0, 0, 0, 1, 1,  0, 0, 1, ALU_ADD, 1);
    addNop(4);
    addV(OP_RTYPE, FN_SUB,    0, 1,    0, 0, 0, 1, 0,  0, 1, 0, ALU_SUB, 1);
    addNop(4);
    addV(OP_BEQ,   6'h00,     1, 0,    1, 1, 0, 0, 0,  0, 0, 0, ALU_SUB, 1);
    addV(OP_BEQ,   6'h00,     0, 0,    0, 1, 0, 0, 0,  0, 0, 0, ALU_SUB, 1);
    addV(OP_RTYPE, FN_ADD,    1, 0,    0, 0, 0, 1, 0,  0, 1, 0, ALU_ADD, 1);
    addV(OP_RTYPE, FN_SUB,    0, 0,    0, 0, 0, 1, 0,  0, 1, 0, ALU_SUB, 1);
    addV(OP_RTYPE, FN_AND,    0, 0,    0, 0, 0, 1, 0,  0, 1, 0, ALU_AND, 1);
    addV(OP_RTYPE, FN_OR,     0, 0,    0, 0, 0, 1, 0,  0, 1, 0, ALU_OR,  1);
    addV(OP_RTYPE, FN_SLT,    0, 0,    0, 0, 0, 1, 0,  0, 1, 0, ALU_SLT, 1);
    addV(OP_SW,    6'h00,     0, 0,    0, 0, 0, 0, 0,  1, 0, 1, ALU_ADD, 1);
    addV(6'b111111, 6'h00,    0, 0,    0, 0, 1, 0, 0,  0, 0, 0, 3'b000,  0);
    addV(OP_RTYPE, 6'b000111, 0, 0,    0, 0, 1, 0, 0,  0, 0, 0, 3'b000,  0);
    addV(OP_BEQ,   6'h00,     1, 1,    1, 1, 0, 0, 0,  0, 0, 0, ALU_SUB, 1);
`ifdef PIPE_CTRL_BNE_EN
    addV(OP_BNE,   6'h00,     0, 0,    1, 1, 0, 0, 0,  0, 0, 0, ALU_SUB, 1);
    addV(OP_BNE,   6'h00,     1, 0,    0, 1, 0, 0, 0,  0, 0, 0, ALU_SUB, 1);
`else
    addV(OP_BNE,   6'h00,     0, 0,    0, 0, 1, 0, 0,  0, 0, 0, 3'b000,  0);
    addV(OP_BNE,   6'h00,     1, 0,    0, 0, 1, 0, 0,  0, 0, 0, 3'b000,  0);
`endif
    for (int i = 0; i < 17; i++)
      addV(OP_ADDI, 6'h00,    0, 0,    0, 0, 0, 1, 0,  0, 0, 1, ALU_ADD, 1);
    addNop(5);

    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(posedge clk);
      #1;
      bus.op = v.op; bus.funct = v.funct; bus.equalID = v.eq; bus.flushE = v.flush;
      v.due = cyc;
      qD.push_back(v);
      e = v;
      if (e.flush) begin
        e.rw = 0; e.mtr = 0; e.mw = 0; e.rd = 0; e.as = 0; e.alu = 3'b000; e.vld = 0;
      end
      e.due = cyc + 1; qE.push_back(e);
      e.due = cyc + 2; qM.push_back(e);
      e.due = cyc + 3; qW.push_back(e);
      retModel = retModel + RETW'(e.vld);
      r.due = cyc + 4; r.val = retModel;
      qR.push_back(r);
    end

    @(posedge clk);
    #1 bus.op = '0; bus.funct = '0; bus.equalID = 1'b0; bus.flushE = 1'b0;
    repeat (6) @(posedge clk);

    // Asynchronous reset in the middle of a stream of addi.
    #1 bus.op = OP_ADDI;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    bus.op = '0;
    @(posedge clk);
    #1 finishReq = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
